// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter and the datapath.
// Widths, load/store decode constants and writeback port indices.
package rf_wb_arbiter_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic WB_ALU  = 1'b0;
    localparam logic WB_LOAD = 1'b1;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback, issue-query and register-file write bundle of the arbiter.
// Handshake: a port transfers in any cycle where valid && ready; the requester holds valid/rd/data stable until then.
interface rf_wb_arbiter_if;
    import rf_wb_arbiter_pkg::*;

    logic            wb0_valid;
    logic [AW-1:0]   wb0_rd;
    logic [XLEN-1:0] wb0_data;
    logic            wb0_ready;
    logic            wb1_valid;
    logic [AW-1:0]   wb1_rd;
    logic [XLEN-1:0] wb1_data;
    logic            wb1_ready;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic            issue_stall;
    logic            RegWrite;
    logic [AW-1:0]   rf_writereg;
    logic [XLEN-1:0] rf_writedata;
    logic [NREG-1:0] busy_vec;

    modport slave (
        input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
        output wb0_ready, wb1_ready, issue_stall,
        output RegWrite, rf_writereg, rf_writedata, busy_vec
    );

    modport master (
        output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
        input  wb0_ready, wb1_ready, issue_stall,
        input  RegWrite, rf_writereg, rf_writedata, busy_vec
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with the RAW/WAW issue stall.
// Set wins over clear on the same index; entry 0 is hard-wired clear.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            nrst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    input  logic            query_valid,
    input  logic [AW-1:0]   query_rs1,
    input  logic [AW-1:0]   query_rs2,
    input  logic [AW-1:0]   query_rd,
    output logic [NREG-1:0] busy_vec,
    output logic            stall
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    // busy_q[0] never sets, so index 0 drops out of every term.
    assign stall    = query_valid &&
                      (busy_q[query_rs1] || busy_q[query_rs2] || busy_q[query_rd]);
    assign busy_vec = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-port writeback arbiter driving the single register-file write port.
// WB_ROUND_ROBIN_EN selects round robin; otherwise the load port wins ties.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
(
    input  logic           clk,
    input  logic           nrst,
    rf_wb_arbiter_if.slave bus
);

    logic            grant0;
    logic            grant1;
    logic            xfer;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            issue_stall;
    logic            sb_set_en;

    logic            reg_write_q,    reg_write_d;
    logic [AW-1:0]   rf_writereg_q,  rf_writereg_d;
    logic [XLEN-1:0] rf_writedata_q, rf_writedata_d;

`ifdef WB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant0       = 1'b0;
        grant1       = 1'b0;
        if (nrst) begin
            if (bus.wb0_valid && bus.wb1_valid) begin
                grant0 = (last_grant_q == WB_LOAD);
                grant1 = (last_grant_q == WB_ALU);
            end else begin
                grant0 = bus.wb0_valid;
                grant1 = bus.wb1_valid;
            end
        end
        last_grant_d = last_grant_q;
        if (grant0)      last_grant_d = WB_ALU;
        else if (grant1) last_grant_d = WB_LOAD;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) last_grant_q <= WB_LOAD;
        else       last_grant_q <= last_grant_d;
    end
`else
    always_comb begin
        grant1 = nrst && bus.wb1_valid;
        grant0 = nrst && bus.wb0_valid && !bus.wb1_valid;
    end
`endif

    assign xfer     = grant0 || grant1;
    assign sel_rd   = grant1 ? bus.wb1_rd   : bus.wb0_rd;
    assign sel_data = grant1 ? bus.wb1_data : bus.wb0_data;

    // x0 transfers are accepted but never raise RegWrite.
    always_comb begin
        reg_write_d    = xfer && (sel_rd != '0);
        rf_writereg_d  = rf_writereg_q;
        rf_writedata_d = rf_writedata_q;
        if (xfer) begin
            rf_writereg_d  = sel_rd;
            rf_writedata_d = sel_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            reg_write_q    <= 1'b0;
            rf_writereg_q  <= '0;
            rf_writedata_q <= '0;
        end else begin
            reg_write_q    <= reg_write_d;
            rf_writereg_q  <= rf_writereg_d;
            rf_writedata_q <= rf_writedata_d;
        end
    end

    assign sb_set_en = bus.issue_valid && !issue_stall && (bus.issue_rd != '0);

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .nrst        (nrst),
        .set_en      (sb_set_en),
        .set_idx     (bus.issue_rd),
        .clr_en      (reg_write_q),
        .clr_idx     (rf_writereg_q),
        .query_valid (bus.issue_valid),
        .query_rs1   (bus.issue_rs1),
        .query_rs2   (bus.issue_rs2),
        .query_rd    (bus.issue_rd),
        .busy_vec    (bus.busy_vec),
        .stall       (issue_stall)
    );

    assign bus.wb0_ready    = grant0;
    assign bus.wb1_ready    = grant1;
    assign bus.issue_stall  = issue_stall;
    assign bus.RegWrite     = reg_write_q;
    assign bus.rf_writereg  = rf_writereg_q;
    assign bus.rf_writedata = rf_writedata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter plus a standalone rf_scoreboard instance.
// Expectations follow WB_ROUND_ROBIN_EN the same way the design does.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int W = AW + XLEN;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    rf_wb_arbiter_if bus();

    rf_wb_arbiter u_dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    logic            sb_set_en, sb_clr_en, sb_qv, sb_stall;
    logic [AW-1:0]   sb_set_idx, sb_clr_idx, sb_rs1, sb_rs2, sb_rd;
    logic [NREG-1:0] sb_busy;

    rf_scoreboard u_sb (
        .clk         (clk),
        .nrst        (nrst),
        .set_en      (sb_set_en),
        .set_idx     (sb_set_idx),
        .clr_en      (sb_clr_en),
        .clr_idx     (sb_clr_idx),
        .query_valid (sb_qv),
        .query_rs1   (sb_rs1),
        .query_rs2   (sb_rs2),
        .query_rd    (sb_rd),
        .busy_vec    (sb_busy),
        .stall       (sb_stall)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    int first;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_wb0(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        bus.wb0_valid = v; bus.wb0_rd = rd; bus.wb0_data = d;
    endtask

    task automatic set_wb1(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        bus.wb1_valid = v; bus.wb1_rd = rd; bus.wb1_data = d;
    endtask

    task automatic set_issue(input logic v, input logic [AW-1:0] rd,
                             input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        bus.issue_valid = v; bus.issue_rd = rd; bus.issue_rs1 = rs1; bus.issue_rs2 = rs2;
    endtask

    // Every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (nrst && bus.RegWrite) begin
            check("wr_pending", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0)
                check("wr_data", {bus.rf_writereg, bus.rf_writedata}, exp_q.pop_front());
        end
    end

    initial begin
        set_wb0(1'b1, 5'd1, 64'h1);
        set_wb1(1'b0, '0, '0);
        set_issue(1'b0, '0, '0, '0);
        sb_set_en = 0; sb_clr_en = 0; sb_qv = 0;
        sb_set_idx = '0; sb_clr_idx = '0; sb_rs1 = '0; sb_rs2 = '0; sb_rd = '0;
`ifdef WB_ROUND_ROBIN_EN
        first = 0;
`else
        first = 1;
`endif

        // Reset state, valid held high during reset
        repeat (2) @(negedge clk);
        #1;
        check("rst_regwrite", bus.RegWrite, 1'b0);
        check("rst_writereg", bus.rf_writereg, 5'd0);
        check("rst_writedata", bus.rf_writedata, 64'd0);
        check("rst_busy", bus.busy_vec, 32'd0);
        check("rst_ready0", bus.wb0_ready, 1'b0);
        @(negedge clk);
        set_wb0(1'b0, '0, '0);
        nrst = 1'b1;

        // Contention straight out of reset
        @(negedge clk);
        set_wb0(1'b1, 5'd3, 64'hA);
        set_wb1(1'b1, 5'd4, 64'hB);
        if (first == 0) begin
            exp_q.push_back({5'd3, 64'hA}); exp_q.push_back({5'd4, 64'hB});
        end else begin
            exp_q.push_back({5'd4, 64'hB}); exp_q.push_back({5'd3, 64'hA});
        end
        #1;
        check("cont_rdy0_a", bus.wb0_ready, first == 0);
        check("cont_rdy1_a", bus.wb1_ready, first == 1);
        @(negedge clk);
        if (first == 0) set_wb0(1'b0, '0, '0);
        else            set_wb1(1'b0, '0, '0);
        check("cont_wr_a", bus.RegWrite, 1'b1);
        check("cont_reg_a", bus.rf_writereg, (first == 0) ? 5'd3 : 5'd4);
        #1;
        check("cont_rdy0_b", bus.wb0_ready, first == 1);
        check("cont_rdy1_b", bus.wb1_ready, first == 0);
        @(negedge clk);
        set_wb0(1'b0, '0, '0);
        set_wb1(1'b0, '0, '0);
        check("cont_wr_b", bus.RegWrite, 1'b1);
        check("cont_reg_b", bus.rf_writereg, (first == 0) ? 5'd4 : 5'd3);
        @(negedge clk);
        check("cont_idle", bus.RegWrite, 1'b0);

        // Single write with latency 1, then hold
        set_wb0(1'b1, 5'd5, 64'h1234);
        exp_q.push_back({5'd5, 64'h1234});
        #1;
        check("single_rdy0", bus.wb0_ready, 1'b1);
        check("single_rdy1", bus.wb1_ready, 1'b0);
        @(negedge clk);
        set_wb0(1'b0, '0, '0);
        check("single_wr", bus.RegWrite, 1'b1);
        check("single_reg", bus.rf_writereg, 5'd5);
        check("single_data", bus.rf_writedata, 64'h1234);
        @(negedge clk);
        check("single_wr_off", bus.RegWrite, 1'b0);
        check("single_reg_hold", bus.rf_writereg, 5'd5);
        check("single_data_hold", bus.rf_writedata, 64'h1234);

        // RAW on x7, resolved by a load writeback
        set_issue(1'b1, 5'd7, 5'd0, 5'd0);
        #1;
        check("raw_issue7_nostall", bus.issue_stall, 1'b0);
        @(negedge clk);
        check("raw_busy7", bus.busy_vec, 32'd1 << 7);
        set_issue(1'b1, 5'd8, 5'd7, 5'd0);
        set_wb1(1'b1, 5'd7, 64'h77);
        exp_q.push_back({5'd7, 64'h77});
        #1;
        check("raw_stall", bus.issue_stall, 1'b1);
        check("raw_rdy1", bus.wb1_ready, 1'b1);
        @(negedge clk);
        set_wb1(1'b0, '0, '0);
        check("raw_wr", bus.RegWrite, 1'b1);
        #1;
        check("raw_stall_in_wr", bus.issue_stall, 1'b1);
        @(negedge clk);
        check("raw_busy_clr", bus.busy_vec, 32'd0);
        #1;
        check("raw_stall_drop", bus.issue_stall, 1'b0);
        @(negedge clk);
        set_issue(1'b0, '0, '0, '0);
        check("raw_busy8", bus.busy_vec, 32'd1 << 8);

        // WAW on x8, then retire it
        set_issue(1'b1, 5'd8, 5'd0, 5'd0);
        #1;
        check("waw_stall", bus.issue_stall, 1'b1);
        @(negedge clk);
        set_issue(1'b0, '0, '0, '0);
        check("waw_no_set", bus.busy_vec, 32'd1 << 8);
        set_wb0(1'b1, 5'd8, 64'h88);
        exp_q.push_back({5'd8, 64'h88});
        @(negedge clk);
        set_wb0(1'b0, '0, '0);
        @(negedge clk);
        check("waw_busy_clr", bus.busy_vec, 32'd0);

        // x0 writeback and x0 issue
        set_wb0(1'b1, 5'd0, 64'hFFFF);
        #1;
        check("x0_rdy0", bus.wb0_ready, 1'b1);
        @(negedge clk);
        set_wb0(1'b0, '0, '0);
        check("x0_no_regwrite", bus.RegWrite, 1'b0);
        set_issue(1'b1, 5'd20, 5'd0, 5'd0);
        @(negedge clk);
        set_issue(1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        check("x0_rs_nostall", bus.issue_stall, 1'b0);
        @(negedge clk);
        set_issue(1'b0, '0, '0, '0);
        check("x0_busy", bus.busy_vec, 32'd1 << 20);

        // Asynchronous reset mid-cycle discards an accepted result
        set_wb0(1'b1, 5'd12, 64'h55);
        exp_q.push_back({5'd12, 64'h55});
        @(negedge clk);
        set_wb0(1'b0, '0, '0);
        check("rst2_wr_before", bus.RegWrite, 1'b1);
        set_wb1(1'b1, 5'd14, 64'h66);
        #1;
        check("rst2_rdy1_before", bus.wb1_ready, 1'b1);
        #1 nrst = 1'b0;
        #1;
        check("rst2_regwrite", bus.RegWrite, 1'b0);
        check("rst2_writereg", bus.rf_writereg, 5'd0);
        check("rst2_writedata", bus.rf_writedata, 64'd0);
        check("rst2_busy", bus.busy_vec, 32'd0);
        check("rst2_rdy1", bus.wb1_ready, 1'b0);
        @(negedge clk);
        set_wb1(1'b0, '0, '0);
        nrst = 1'b1;
        @(negedge clk);
        check("rst2_discarded", bus.RegWrite, 1'b0);

        // Standalone scoreboard: same-cycle set and clear
        sb_set_en = 1'b1; sb_set_idx = 5'd9;
        @(negedge clk);
        sb_set_en = 1'b0;
        check("sb_set9", sb_busy, 32'd1 << 9);
        sb_qv = 1'b1; sb_rs1 = 5'd9;
        #1;
        check("sb_stall9", sb_stall, 1'b1);
        sb_qv = 1'b0; sb_rs1 = '0;
        sb_set_en = 1'b1; sb_set_idx = 5'd9; sb_clr_en = 1'b1; sb_clr_idx = 5'd9;
        @(negedge clk);
        check("sb_setclr_same", sb_busy, 32'd1 << 9);
        sb_set_en = 1'b0;
        @(negedge clk);
        check("sb_clr9", sb_busy, 32'd0);
        sb_clr_en = 1'b0;
        sb_set_en = 1'b1; sb_set_idx = 5'd0;
        @(negedge clk);
        sb_set_en = 1'b0;
        check("sb_x0_never", sb_busy, 32'd0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (RegWrite / rf_writereg / rf_writedata) between two writeback requesters: port 0 (ALU/ADDI/JAL/JALR result) and port 1 (LD/LW/LWU/LH/LHU load data).
- Holds a per-register pending scoreboard, set at issue and cleared at the writeback edge.
- Issue logic uses it to stall on RAW/WAW hazards.
- Sits between the EX/MEM completion stages and registerfile.

Parameters:
- XLEN, 64, data width of the write port.
- NREG, 32, number of architectural registers.
- AW, 5, register index width (log2 NREG).

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- wb0_valid  in  1  port 0 has a result.
- wb0_rd  in  AW  port 0 destination register.
- wb0_data  in  XLEN  port 0 result.
- wb0_ready  out  1  port 0 accepted this cycle.
- wb1_valid  in  1  port 1 has a result.
- wb1_rd  in  AW  port 1 destination register.
- wb1_data  in  XLEN  port 1 result.
- wb1_ready  out  1  port 1 accepted this cycle.
- issue_valid  in  1  instruction issuing this cycle, writes a register.
- issue_rd  in  AW  its destination register.
- issue_rs1  in  AW  source register 1 query.
- issue_rs2  in  AW  source register 2 query.
- issue_stall  out  1  hazard; issue must hold.
- RegWrite  out  1  to registerfile.
- rf_writereg  out  AW  to registerfile.
- rf_writedata  out  XLEN  to registerfile.
- busy_vec  out  NREG  pending-write scoreboard, for debug/forwarding.

Behaviour:
- Reset (nrst low, async):
  - RegWrite=0, rf_writereg=0, rf_writedata=0.
  - busy_vec=0.
  - last_grant=1, so port 0 wins first.
  - Reset mid-transfer discards any accepted-but-unwritten result.
- Handshake:
  - A transfer occurs on a port when valid && ready in the same cycle.
  - wbN_ready is combinational from the valids and last_grant, and at most one is high per cycle.
  - A requester holds valid, rd and data stable until ready.
  - No ready is given while nrst is low.
- Arbitration:
  - Only one valid: that port is granted.
  - Both valid: the port opposite last_grant is granted (round robin).
  - last_grant updates only on a transfer.
- Write output (registered, latency 1):
  - A transfer in cycle N drives RegWrite=1 with rf_writereg/rf_writedata in cycle N+1, so registerfile writes at the end of N+1.
  - No transfer in cycle N gives RegWrite=0 in N+1; rf_writereg/rf_writedata hold their previous values.
  - Throughput is one write per cycle.
- x0:
  - A transfer with rd=0 is accepted but produces RegWrite=0.
  - issue_rd=0 never sets a busy bit.
  - busy_vec[0] is always 0.
- Scoreboard:
  - Set: busy[issue_rd] is set at the edge ending a cycle with issue_valid && !issue_stall && issue_rd!=0.
  - Clear: busy[rf_writereg] is cleared at the edge ending a cycle with RegWrite=1.
  - Busy stays visible through cycle N+1, so no reader sees a stale value.
  - Set and clear on the same index in the same cycle: set wins.
- Stall, combinational:
  - issue_stall = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]).
  - Index 0 contributes 0 to every term.
  - The busy[issue_rd] term blocks WAW, so at most one write is outstanding per register.
- Misuse: a write to a register that is not busy is performed normally. No error is flagged.

Optional Feature:
- Macro WB_ROUND_ROBIN_EN.
- Defined: round robin as described above, with the last_grant flop present.
- Undefined: fixed priority, port 1 (load) always wins ties; last_grant is removed and port 0 waits while wb1_valid is high.

Decomposition:
- Shared package (defines header) holds:
  - XLEN/NREG/AW constants.
  - The load/store funct3 and opcode constants already used by the datapath.
  - Port index constants WB_ALU=0 and WB_LOAD=1.
- One sub-module, rf_scoreboard, holds the busy vector with set/clear/query logic and the stall equation.
- The arbiter and output register stay in the top module.

Test Plan:
- Reset: assert nrst low mid-cycle → all outputs 0 immediately; busy_vec=0; ready low.
- Single write: wb0 valid, rd=5, data=64'h1234 in cycle 1 → wb0_ready=1 in cycle 1; in cycle 2 RegWrite=1, rf_writereg=5, rf_writedata=64'h1234; cycle 3 RegWrite=0.
- Contention: wb0 (rd=3, 64'hA) and wb1 (rd=4, 64'hB) held valid together → grants alternate 0,1 (port 0 first after reset); with WB_ROUND_ROBIN_EN undefined, port 1 is granted first and port 0 waits one cycle.
- Scoreboard RAW:
  - Issue rd=7; next cycle issue rs1=7 → issue_stall=1.
  - wb1 writes rd=7 → stall stays 1 in the RegWrite cycle and drops to 0 the cycle after.
- Same-cycle set/clear on rd=9: RegWrite to 9 while issuing rd=9 unstalled is not reachable (WAW stalls it), so force via scoreboard sub-module bench → busy[9] remains 1.
- x0: wb0 rd=0 data=64'hFFFF → wb0_ready=1, RegWrite stays 0; issue rd=0 → busy_vec unchanged; rs1=0 never stalls.
